uart_tx_scheduler: RTL

- Shares one `uart` transmitter byte stream (its `s_axis_*` input) between N_SRC packetised AXI-stream requesters.
- Round-robin arbitration at packet granularity. A channel-ID header byte is inserted before each packet.
- Enforces a maximum burst length and a programmable idle gap after each packet. The gap is timed from the end of `tx_busy`.
- Sits between the per-client byte sources and the `uart` instance.

---
 rtl/uart_sched_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/uart_tx_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the uart transmit scheduler.
// The header byte carries a fixed marker nibble above the granted channel id.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    DATA    = 3'd2,
    WAIT_TX = 3'd3,
    GAP     = 3'd4
  } state_t;

  localparam logic [3:0] HDR_MARK = 4'hA;

  function automatic logic [7:0] hdr_byte(input logic [3:0] id);
    return {HDR_MARK, id};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [IW-1:0] gnt_id,
  output logic          gnt_valid
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt_id    = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    if (en) begin
      for (int unsigned i = 1; i <= N; i++) begin
        idx = IW'((32'(ptr) + i) % N);
        if (!gnt_valid && req[idx]) begin
          gnt_valid = 1'b1;
          gnt_id    = idx;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Packet-granular round-robin sharing of one uart byte stream among N_SRC sources,
// with optional channel header, burst truncation at MAX_PKT and a post-transmit idle gap.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int unsigned N_SRC      = 4,
  parameter int unsigned MAX_PKT    = 64,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned HDR_EN     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*N_SRC-1:0] s_axis_tdata,
  input  logic [N_SRC-1:0]   s_axis_tvalid,
  input  logic [N_SRC-1:0]   s_axis_tlast,
  output logic [N_SRC-1:0]   s_axis_tready,
  output logic [7:0]         m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  input  logic               tx_busy,
  output logic [3:0]         grant_id,
  output logic               active,
  output logic               trunc_pulse
);

  localparam int unsigned IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [15:0]   gap_q, gap_d;
  logic          armed_q, armed_d;
  logic          active_q;
  logic          trunc_q, trunc_d;

  logic [IW-1:0] arb_id;
  logic          arb_valid;
  logic [7:0]    sel_data;
  logic          sel_valid;
  logic          sel_last;

  rr_arbiter #(
    .N  (N_SRC),
    .IW (IW)
  ) u_arb (
    .req       (s_axis_tvalid),
    .ptr       (ptr_q),
    .en        (state_q == IDLE),
    .gnt_id    (arb_id),
    .gnt_valid (arb_valid)
  );

  assign sel_data  = s_axis_tdata[{grant_q, 3'b000} +: 8];
  assign sel_valid = s_axis_tvalid[grant_q];
  assign sel_last  = s_axis_tlast[grant_q];

  assign grant_id    = 4'(grant_q);
  assign active      = active_q;
  assign trunc_pulse = trunc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= IW'(N_SRC - 1);
      grant_q  <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      armed_q  <= 1'b0;
      active_q <= 1'b0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      armed_q  <= armed_d;
      active_q <= (state_d != IDLE);
      trunc_q  <= trunc_d;
    end
  end

  // Next state plus the combinational stream path; DATA is a zero-latency pass-through.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    armed_d       = armed_q;
    trunc_d       = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    s_axis_tready = '0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_id;
          ptr_d   = arb_id;
          cnt_d   = '0;
          state_d = (HDR_EN != 0) ? HDR : DATA;
        end
      end

      HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_byte(4'(grant_q));
        if (m_axis_tready) begin
          state_d = DATA;
        end
      end

      DATA: begin
        m_axis_tvalid          = sel_valid;
        m_axis_tdata           = sel_data;
        s_axis_tready[grant_q] = m_axis_tready;
        if (sel_valid && m_axis_tready) begin
          cnt_d = cnt_q + 8'd1;
          if (sel_last) begin
            state_d = WAIT_TX;
            cnt_d   = '0;
            armed_d = 1'b0;
          end else if (cnt_q + 8'd1 == 8'(MAX_PKT)) begin
            state_d = WAIT_TX;
            cnt_d   = '0;
            armed_d = 1'b0;
            trunc_d = 1'b1;
          end
        end
      end

      // First cycle only arms, so the uart has had a cycle to raise tx_busy.
      WAIT_TX: begin
        if (!armed_q) begin
          armed_d = 1'b1;
        end else if (!tx_busy) begin
          armed_d = 1'b0;
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            gap_d   = 16'(GAP_CYCLES);
            state_d = GAP;
          end
        end
      end

      GAP: begin
        gap_d = gap_q - 16'd1;
        if (gap_q <= 16'd1) begin
          gap_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
